// File: rtl/apb_rx_ctrl.sv
// UART RX sequencer: input synchroniser, baud prescaler, start-bit validation and the
// IDLE/START/DATA/STOP/BREAK frame walk that steers apb_rx_dp.
module apb_rx_ctrl #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned DIV_W      = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sel,
    input  logic             rx_en,
    input  logic             rx_in,
    input  logic [DIV_W-1:0] baud_div,
    output logic             start_bit,
    output logic             end_bit,
    output logic [9:0]       data_bit,
    output logic [9:0]       bit_cnto,
    output logic             sample_stb,
    output logic             rx_s,
    output logic             busy,
    output logic             rx_done,
    output logic             frame_err
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    localparam logic [9:0] OsHalf  = 10'(OVERSAMPLE / 2 - 1);
    localparam logic [9:0] OsLast  = 10'(OVERSAMPLE - 1);
    localparam logic [9:0] LastBit = 10'(DATA_BITS - 1);

    state_e           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] div_eff;
    logic [9:0]       os_q, os_d;
    logic [9:0]       db_q, db_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;
    logic             run;
    logic             tick;

    assign run = sel & rx_en;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_comb begin
        sync_d = {sync_q[0], rx_in};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rx_s = sync_q[1];

    // Prescaler: divisor is captured at each wrap (and while idle) so a mid-frame change
    // only lands on a tick boundary; held at 0 while idle so the first tick is a full period.
    always_comb begin
        div_eff = (baud_div == '0) ? DIV_W'(1) : baud_div;
        tick    = (state_q != StIdle) && (presc_q == div_q - DIV_W'(1));
        presc_d = presc_q + DIV_W'(1);
        div_d   = div_q;
        if ((state_q == StIdle) || !run || tick) begin
            presc_d = '0;
            div_d   = div_eff;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc_q <= '0;
            div_q   <= DIV_W'(1);
        end else begin
            presc_q <= presc_d;
            div_q   <= div_d;
        end
    end

    // Frame walk: next state, counters, sample strobe and completion pulses.
    always_comb begin
        state_d    = state_q;
        os_d       = os_q;
        db_d       = db_q;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        sample_stb = 1'b0;

        case (state_q)
            StIdle: begin
                if (run && !rx_s) begin
                    state_d = StStart;
                    os_d    = '0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (os_q == OsHalf) begin
                        os_d = '0;
                        if (!rx_s) begin
                            state_d = StData;
                            db_d    = '0;
                        end else begin
                            // Line went back high before mid-bit: treat as a glitch.
                            state_d = StIdle;
                        end
                    end else begin
                        os_d = os_q + 10'd1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (os_q == OsLast) begin
                        sample_stb = 1'b1;
                        os_d       = '0;
                        if (db_q == LastBit) begin
                            state_d = StStop;
                        end else begin
                            db_d = db_q + 10'd1;
                        end
                    end else begin
                        os_d = os_q + 10'd1;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    if (os_q == OsLast) begin
                        os_d = '0;
                        if (rx_s) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = StBreak;
                        end
                    end else begin
                        os_d = os_q + 10'd1;
                    end
                end
            end
            StBreak: begin
                // Hold here until the line recovers so a stuck-low line cannot start a frame.
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                os_d    = '0;
            end
        endcase

        // Losing sel/rx_en silently aborts the frame.
        if ((state_q != StIdle) && !run) begin
            state_d    = StIdle;
            os_d       = '0;
            db_d       = '0;
            done_d     = 1'b0;
            ferr_d     = 1'b0;
            sample_stb = 1'b0;
        end
    end

    // State, counter and pulse registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            os_q    <= '0;
            db_q    <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            os_q    <= os_d;
            db_q    <= db_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        start_bit = (state_q == StStart);
        end_bit   = (state_q == StStop);
        busy      = (state_q != StIdle);
        data_bit  = db_q;
        bit_cnto  = os_q;
        rx_done   = done_q;
        frame_err = ferr_q;
    end

`ifndef SYNTHESIS
    // Pulses are exclusive and the oversample counter never passes the last tick.
    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!(done_q && ferr_q));
            assert (os_q <= OsLast);
        end
    end
`endif

endmodule

// File: tb/tb_apb_rx_ctrl.sv
// Directed bench for apb_rx_ctrl: frames are driven on rx_in and the sample strobes and
// completion pulses are collected by a monitor, then checked by each scenario task.
module tb_apb_rx_ctrl;

    localparam int OS = 16;
    localparam int DB = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          sel = 1'b0;
    logic          rx_en = 1'b0;
    logic          rx_in = 1'b1;
    logic [DW-1:0] baud_div = 16'd1;
    logic          start_bit, end_bit, sample_stb, rx_s, busy, rx_done, frame_err;
    logic [9:0]    data_bit, bit_cnto;

    apb_rx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(DB), .DIV_W(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sel       (sel),
        .rx_en     (rx_en),
        .rx_in     (rx_in),
        .baud_div  (baud_div),
        .start_bit (start_bit),
        .end_bit   (end_bit),
        .data_bit  (data_bit),
        .bit_cnto  (bit_cnto),
        .sample_stb(sample_stb),
        .rx_s      (rx_s),
        .busy      (busy),
        .rx_done   (rx_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor, sampled on the falling edge.
    logic [9:0] stb_idx[$];
    logic       stb_val[$];
    int         stb_cyc[$];
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    int         start_seen = 0;
    int         max_os = 0;

    always @(negedge clk) begin
        if (sample_stb === 1'b1) begin
            stb_idx.push_back(data_bit);
            stb_val.push_back(rx_s);
            stb_cyc.push_back(cyc);
        end
        if (rx_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) ferr_cnt++;
        if (rx_done === 1'b1 && frame_err === 1'b1) both_cnt++;
        if (start_bit === 1'b1) start_seen++;
        if (int'(bit_cnto) > max_os) max_os = int'(bit_cnto);
    end

    task automatic clear_mon();
        stb_idx.delete();
        stb_val.delete();
        stb_cyc.delete();
        done_cnt   = 0;
        ferr_cnt   = 0;
        start_seen = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start, DB data bits LSB first, then the stop level; returns the fall cycle.
    task automatic send_frame(input logic [7:0] data, input logic stop, input int div,
                              output int fall);
        rx_in = 1'b0;
        fall  = cyc;
        step(OS * div);
        for (int i = 0; i < DB; i++) begin
            rx_in = data[i];
            step(OS * div);
        end
        rx_in = stop;
        step(OS * div);
        rx_in = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step(3);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (rx_s !== 1'b1) begin n_bad++; $display("FAIL reset_rx_s: got %b want 1", rx_s); end
        n_cmp++; if (data_bit !== 10'd0 || bit_cnto !== 10'd0) begin
            n_bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", data_bit, bit_cnto);
        end
        n_cmp++; if ({start_bit, end_bit, sample_stb, rx_done, frame_err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 00000",
                              {start_bit, end_bit, sample_stb, rx_done, frame_err});
        end
        rstn = 1'b1;
        sel = 1'b1;
        rx_en = 1'b1;
        step(4);
    endtask

    task automatic test_frame_a5();
        int fall;
        logic [7:0] d;
        d = 8'hA5;
        baud_div = 16'd1;
        clear_mon();
        send_frame(d, 1'b1, 1, fall);
        step(6);
        n_cmp++; if (stb_val.size() != 8) begin n_bad++; $display("FAIL a5_stb_count: got %0d want 8", stb_val.size()); end
        for (int k = 0; k < 8 && k < stb_val.size(); k++) begin
            n_cmp++; if (stb_idx[k] !== 10'(k) || stb_val[k] !== d[k]) begin
                n_bad++; $display("FAIL a5_bit%0d: got idx %0d val %b want idx %0d val %b",
                                  k, stb_idx[k], stb_val[k], k, d[k]);
            end
            n_cmp++; if (stb_cyc[k] - fall < 26 + 16 * k - 1 || stb_cyc[k] - fall > 26 + 16 * k + 1) begin
                n_bad++; $display("FAIL a5_time%0d: got %0d want %0d+-1", k, stb_cyc[k] - fall, 26 + 16 * k);
            end
        end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL a5_done: got %0d want 1", done_cnt); end
        n_cmp++; if (ferr_cnt != 0) begin n_bad++; $display("FAIL a5_ferr: got %0d want 0", ferr_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL a5_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx_in = 1'b0;
        step(5);
        rx_in = 1'b1;
        step(30);
        n_cmp++; if (start_seen == 0) begin n_bad++; $display("FAIL glitch_start: got 0 cycles want >0"); end
        n_cmp++; if (stb_val.size() != 0) begin n_bad++; $display("FAIL glitch_stb: got %0d want 0", stb_val.size()); end
        n_cmp++; if (done_cnt != 0 || ferr_cnt != 0) begin
            n_bad++; $display("FAIL glitch_pulses: got %0d/%0d want 0/0", done_cnt, ferr_cnt);
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy: got %b want 0", busy); end
    endtask

    task automatic test_frame_err();
        logic [7:0] d;
        d = 8'h3C;
        clear_mon();
        rx_in = 1'b0;
        step(OS);
        for (int i = 0; i < DB; i++) begin
            rx_in = d[i];
            step(OS);
        end
        rx_in = 1'b0;
        step(40);
        n_cmp++; if (ferr_cnt != 1) begin n_bad++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt); end
        n_cmp++; if (busy !== 1'b1 || start_bit !== 1'b0 || end_bit !== 1'b0) begin
            n_bad++; $display("FAIL ferr_break: got busy %b start %b end %b want 1 0 0", busy, start_bit, end_bit);
        end
        n_cmp++; if (stb_val.size() != 8) begin n_bad++; $display("FAIL ferr_stb_count: got %0d want 8", stb_val.size()); end
        for (int k = 0; k < 8 && k < stb_val.size(); k++) begin
            n_cmp++; if (stb_val[k] !== d[k]) begin
                n_bad++; $display("FAIL ferr_bit%0d: got %b want %b", k, stb_val[k], d[k]);
            end
        end
        rx_in = 1'b1;
        step(5);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ferr_idle: got busy %b want 0", busy); end
        step(20);
        n_cmp++; if (done_cnt != 0 || ferr_cnt != 1) begin
            n_bad++; $display("FAIL ferr_final: got done %0d ferr %0d want 0 1", done_cnt, ferr_cnt);
        end
    endtask

    task automatic test_abort();
        int fall;
        logic [7:0] d;
        d = 8'h5A;
        clear_mon();
        rx_in = 1'b0;
        step(OS);
        for (int i = 0; i < 3; i++) begin
            rx_in = d[i];
            step(OS);
        end
        rx_in = d[3];
        step(4);
        n_cmp++; if (data_bit !== 10'd3 || busy !== 1'b1) begin
            n_bad++; $display("FAIL abort_pre: got data_bit %0d busy %b want 3 1", data_bit, busy);
        end
        rx_en = 1'b0;
        step(1);
        n_cmp++; if (busy !== 1'b0 || bit_cnto !== 10'd0 || data_bit !== 10'd0) begin
            n_bad++; $display("FAIL abort_idle: got busy %b os %0d db %0d want 0 0 0", busy, bit_cnto, data_bit);
        end
        rx_in = 1'b0;
        step(30);
        rx_in = 1'b1;
        step(200);
        n_cmp++; if (done_cnt != 0 || ferr_cnt != 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL abort_pulses: got done %0d ferr %0d busy %b want 0 0 0", done_cnt, ferr_cnt, busy);
        end
        rx_en = 1'b1;
        step(5);
        clear_mon();
        send_frame(d, 1'b1, 1, fall);
        step(6);
        n_cmp++; if (stb_val.size() != 8 || done_cnt != 1 || ferr_cnt != 0) begin
            n_bad++; $display("FAIL abort_next: got stb %0d done %0d ferr %0d want 8 1 0",
                              stb_val.size(), done_cnt, ferr_cnt);
        end
        for (int k = 0; k < 8 && k < stb_val.size(); k++) begin
            n_cmp++; if (stb_val[k] !== d[k] || stb_idx[k] !== 10'(k)) begin
                n_bad++; $display("FAIL abort_next_bit%0d: got %b idx %0d want %b idx %0d",
                                  k, stb_val[k], stb_idx[k], d[k], k);
            end
        end
    endtask

    task automatic test_back_to_back();
        int fall0, fall1;
        logic [15:0] exp;
        exp = 16'hFF00;
        baud_div = 16'd3;
        clear_mon();
        send_frame(8'h00, 1'b1, 3, fall0);
        send_frame(8'hFF, 1'b1, 3, fall1);
        step(12);
        n_cmp++; if (done_cnt != 2 || ferr_cnt != 0) begin
            n_bad++; $display("FAIL b2b_pulses: got done %0d ferr %0d want 2 0", done_cnt, ferr_cnt);
        end
        n_cmp++; if (stb_val.size() != 16) begin n_bad++; $display("FAIL b2b_stb_count: got %0d want 16", stb_val.size()); end
        for (int k = 0; k < 16 && k < stb_val.size(); k++) begin
            int f;
            int nom;
            f   = (k < 8) ? fall0 : fall1;
            nom = f + 72 + 48 * (k % 8);
            n_cmp++; if (stb_val[k] !== exp[k] || stb_idx[k] !== 10'(k % 8)) begin
                n_bad++; $display("FAIL b2b_bit%0d: got %b idx %0d want %b idx %0d",
                                  k, stb_val[k], stb_idx[k], exp[k], k % 8);
            end
            n_cmp++; if (stb_cyc[k] < nom - 3 || stb_cyc[k] > nom + 3) begin
                n_bad++; $display("FAIL b2b_time%0d: got %0d want %0d+-3", k, stb_cyc[k], nom);
            end
            if (k % 8 != 0) begin
                n_cmp++; if (stb_cyc[k] - stb_cyc[k-1] != 48) begin
                    n_bad++; $display("FAIL b2b_spacing%0d: got %0d want 48", k, stb_cyc[k] - stb_cyc[k-1]);
                end
            end
        end
        baud_div = 16'd1;
        step(4);
    endtask

    task automatic test_async_reset();
        int fall;
        logic [7:0] d;
        d = 8'h81;
        clear_mon();
        rx_in = 1'b0;
        step(OS);
        rx_in = d[0];
        step(OS);
        rx_in = d[1];
        step(8);
        n_cmp++; if (busy !== 1'b1 || data_bit !== 10'd1) begin
            n_bad++; $display("FAIL rst_pre: got busy %b db %0d want 1 1", busy, data_bit);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || data_bit !== 10'd0 || bit_cnto !== 10'd0) begin
            n_bad++; $display("FAIL rst_async_cnt: got busy %b db %0d os %0d want 0 0 0", busy, data_bit, bit_cnto);
        end
        n_cmp++; if (rx_s !== 1'b1) begin n_bad++; $display("FAIL rst_async_rx_s: got %b want 1", rx_s); end
        n_cmp++; if ({start_bit, end_bit, sample_stb, rx_done, frame_err} !== 5'b0) begin
            n_bad++; $display("FAIL rst_async_flags: got %b want 00000",
                              {start_bit, end_bit, sample_stb, rx_done, frame_err});
        end
        rx_in = 1'b1;
        step(3);
        rstn = 1'b1;
        step(5);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_release_idle: got %b want 0", busy); end
        clear_mon();
        send_frame(d, 1'b1, 1, fall);
        step(6);
        n_cmp++; if (stb_val.size() != 8 || done_cnt != 1 || ferr_cnt != 0) begin
            n_bad++; $display("FAIL rst_next: got stb %0d done %0d ferr %0d want 8 1 0",
                              stb_val.size(), done_cnt, ferr_cnt);
        end
        for (int k = 0; k < 8 && k < stb_val.size(); k++) begin
            n_cmp++; if (stb_val[k] !== d[k]) begin
                n_bad++; $display("FAIL rst_next_bit%0d: got %b want %b", k, stb_val[k], d[k]);
            end
        end
    endtask

    task automatic test_invariants();
        n_cmp++; if (both_cnt != 0) begin n_bad++; $display("FAIL pulse_overlap: got %0d want 0", both_cnt); end
        n_cmp++; if (max_os > OS - 1) begin n_bad++; $display("FAIL os_max: got %0d want <=%0d", max_os, OS - 1); end
    endtask

    initial begin
        #1;
        test_reset();
        test_frame_a5();
        test_glitch();
        test_frame_err();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
